// File: rtl/fft_din_pingpong.sv
// Two-bank frame buffer between the USB frame source and the FFT core input.
// Frames leave in arrival order, optionally with lanes permuted into bit-reversed order.
module fft_din_pingpong #(
  parameter int NPOINT = 3,
  parameter int DW     = 16,
  parameter int BITREV = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_busy,
  input  logic [DW*(2**NPOINT)-1:0] in_real,
  input  logic [DW*(2**NPOINT)-1:0] in_imag,
  output logic                     out_valid,
  input  logic                     out_busy,
  output logic [DW*(2**NPOINT)-1:0] out_real,
  output logic [DW*(2**NPOINT)-1:0] out_imag,
  output logic [15:0]              frame_cnt,
  output logic                     drop_stall
);

  localparam int NL = 2**NPOINT;
  localparam int W  = DW*NL;

  logic [1:0][W-1:0] bank_real_q, bank_real_d;
  logic [1:0][W-1:0] bank_imag_q, bank_imag_d;
  logic [1:0]        full_q, full_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              drop_stall_q, drop_stall_d;
  logic [W-1:0]      out_real_q, out_real_d;
  logic [W-1:0]      out_imag_q, out_imag_d;
  logic              wr_en, rd_en;

  function automatic logic [NPOINT-1:0] rev_idx(input logic [NPOINT-1:0] k);
    logic [NPOINT-1:0] r;
    for (int i = 0; i < NPOINT; i++) r[i] = k[NPOINT-1-i];
    return r;
  endfunction

  function automatic logic [W-1:0] map_lanes(input logic [W-1:0] x);
    logic [W-1:0]      y;
    logic [NPOINT-1:0] src;
    y = '0;
    for (int k = 0; k < NL; k++) begin
      src = (BITREV != 0) ? rev_idx(NPOINT'(k)) : NPOINT'(k);
      y[DW*k +: DW] = x[DW*src +: DW];
    end
    return y;
  endfunction

  assign in_busy    = full_q[wr_sel_q];
  assign out_valid  = full_q[rd_sel_q];
  assign out_real   = out_real_q;
  assign out_imag   = out_imag_q;
  assign frame_cnt  = frame_cnt_q;
  assign drop_stall = drop_stall_q;

  assign wr_en = in_valid && !full_q[wr_sel_q];
  assign rd_en = full_q[rd_sel_q] && !out_busy;

  always_comb begin
    full_d       = full_q;
    wr_sel_d     = wr_sel_q;
    rd_sel_d     = rd_sel_q;
    bank_real_d  = bank_real_q;
    bank_imag_d  = bank_imag_q;
    frame_cnt_d  = frame_cnt_q;
    drop_stall_d = in_valid && full_q[wr_sel_q];
    // Read and write can never target the same bank in one cycle.
    if (rd_en) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
    if (wr_en) begin
      full_d[wr_sel_q]      = 1'b1;
      bank_real_d[wr_sel_q] = in_real;
      bank_imag_d[wr_sel_q] = in_imag;
      wr_sel_d              = ~wr_sel_q;
      frame_cnt_d           = frame_cnt_q + 16'd1;
    end
    // Output register tracks the next head-of-queue so data is ready one cycle after accept.
    out_real_d = full_d[rd_sel_d] ? map_lanes(bank_real_d[rd_sel_d]) : '0;
    out_imag_d = full_d[rd_sel_d] ? map_lanes(bank_imag_d[rd_sel_d]) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q       <= '0;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      frame_cnt_q  <= '0;
      drop_stall_q <= 1'b0;
      out_real_q   <= '0;
      out_imag_q   <= '0;
    end else begin
      full_q       <= full_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_stall_q <= drop_stall_d;
      out_real_q   <= out_real_d;
      out_imag_q   <= out_imag_d;
    end
  end

  always_ff @(posedge clk) begin
    bank_real_q <= bank_real_d;
    bank_imag_q <= bank_imag_d;
  end

endmodule

// File: tb/tb_fft_din_pingpong.sv
// Directed bench: natural-order and bit-reversed instances share one stimulus stream.
module tb_fft_din_pingpong;

  localparam int NPOINT = 3;
  localparam int DW     = 16;
  localparam int NL     = 8;
  localparam int W      = DW*NL;
  localparam int REV [NL] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_busy;
  logic [W-1:0] in_real, in_imag;
  logic         in_busy0, out_valid0, drop_stall0;
  logic         in_busy1, out_valid1, drop_stall1;
  logic [W-1:0] out_real0, out_imag0, out_real1, out_imag1;
  logic [15:0]  frame_cnt0, frame_cnt1;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fft_din_pingpong #(.NPOINT(NPOINT), .DW(DW), .BITREV(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_busy(in_busy0),
    .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid0), .out_busy(out_busy),
    .out_real(out_real0), .out_imag(out_imag0), .frame_cnt(frame_cnt0), .drop_stall(drop_stall0)
  );

  fft_din_pingpong #(.NPOINT(NPOINT), .DW(DW), .BITREV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_busy(in_busy1),
    .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid1), .out_busy(out_busy),
    .out_real(out_real1), .out_imag(out_imag1), .frame_cnt(frame_cnt1), .drop_stall(drop_stall1)
  );

  // Frame whose lane k holds base+k; rev=1 gives the bit-reversed view of that frame.
  function automatic logic [W-1:0] frm(input logic [15:0] base, input bit rev);
    logic [W-1:0] f;
    for (int k = 0; k < NL; k++) f[DW*k +: DW] = base + 16'(rev ? REV[k] : k);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] rb, input logic [15:0] ib);
    chk16({tag, "_valid"}, 16'(out_valid0), 16'd1);
    chk({tag, "_re"},    out_real0, frm(rb, 0));
    chk({tag, "_im"},    out_imag0, frm(ib, 0));
    chk({tag, "_re_br"}, out_real1, frm(rb, 1));
    chk({tag, "_im_br"}, out_imag1, frm(ib, 1));
  endtask

  task automatic chk_empty(input string tag);
    chk16({tag, "_valid"}, 16'({out_valid0, out_valid1}), 16'd0);
    chk({tag, "_re"}, out_real0 | out_real1, '0);
    chk({tag, "_im"}, out_imag0 | out_imag1, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    out_busy = 1'b0;
    in_real  = '0;
    in_imag  = '0;
    do_reset();

    chk16("rst_in_busy", 16'({in_busy0, in_busy1}), 16'd0);
    chk16("rst_frame_cnt", frame_cnt0, 16'd0);
    chk16("rst_drop_stall", 16'(drop_stall0), 16'd0);
    chk_empty("rst_out");

    // Single frame, both lane orders
    in_real  = frm(16'h0000, 0);
    in_imag  = frm(16'h0100, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_out("single", 16'h0000, 16'h0100);
    chk({"single_br_lit"}, out_real1,
        {16'h0007, 16'h0003, 16'h0005, 16'h0001, 16'h0006, 16'h0002, 16'h0004, 16'h0000});
    step();
    chk_empty("single_after_read");
    chk16("single_frame_cnt", frame_cnt0, 16'd1);

    // Back-pressure: A, B held, C stalled
    do_reset();
    out_busy = 1'b1;
    in_valid = 1'b1;
    in_real  = frm(16'hA000, 0);
    in_imag  = frm(16'hA800, 0);
    step();
    chk_out("bp_A_head", 16'hA000, 16'hA800);
    chk16("bp_busy_1", 16'(in_busy0), 16'd0);
    in_real = frm(16'hB000, 0);
    in_imag = frm(16'hB800, 0);
    step();
    chk16("bp_busy_2", 16'(in_busy0), 16'd1);
    chk16("bp_cnt_2", frame_cnt0, 16'd2);
    chk16("bp_drop_0", 16'(drop_stall0), 16'd0);
    in_real = frm(16'hC000, 0);
    in_imag = frm(16'hC800, 0);
    step();
    chk16("bp_drop_1", 16'(drop_stall0), 16'd1);
    chk16("bp_cnt_stall", frame_cnt0, 16'd2);
    chk_out("bp_A_hold", 16'hA000, 16'hA800);
    step();
    chk16("bp_drop_2", 16'(drop_stall0), 16'd1);
    out_busy = 1'b0;
    step();
    chk_out("bp_B", 16'hB000, 16'hB800);
    chk16("bp_busy_rel", 16'(in_busy0), 16'd0);
    chk16("bp_drop_3", 16'(drop_stall0), 16'd1);
    step();
    in_valid = 1'b0;
    chk_out("bp_C", 16'hC000, 16'hC800);
    chk16("bp_cnt_3", frame_cnt0, 16'd3);
    chk16("bp_drop_clr", 16'(drop_stall0), 16'd0);
    step();
    chk_empty("bp_drained");

    // Streaming one frame per cycle
    do_reset();
    out_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_real  = frm(16'h1000 + 16'(i*8), 0);
      in_imag  = frm(16'h2000 + 16'(i*8), 0);
      step();
      chk16($sformatf("str_busy_%0d", i), 16'(in_busy0), 16'd0);
      chk_out($sformatf("str_%0d", i), 16'h1000 + 16'(i*8), 16'h2000 + 16'(i*8));
    end
    in_valid = 1'b0;
    step();
    chk_empty("str_end");
    chk16("str_cnt", frame_cnt0, 16'd20);

    // Simultaneous read and write with one bank full
    do_reset();
    out_busy = 1'b1;
    in_valid = 1'b1;
    in_real  = frm(16'h3000, 0);
    in_imag  = frm(16'h3800, 0);
    step();
    out_busy = 1'b0;
    in_real  = frm(16'h4000, 0);
    in_imag  = frm(16'h4800, 0);
    step();
    in_valid = 1'b0;
    chk_out("sim_next", 16'h4000, 16'h4800);
    chk16("sim_busy", 16'(in_busy0), 16'd0);
    chk16("sim_cnt", frame_cnt0, 16'd2);
    step();
    chk_empty("sim_drained");

    // Reset while both banks are full
    do_reset();
    out_busy = 1'b1;
    in_valid = 1'b1;
    in_real  = frm(16'h5000, 0);
    in_imag  = frm(16'h5800, 0);
    step();
    in_real  = frm(16'h6000, 0);
    in_imag  = frm(16'h6800, 0);
    step();
    chk16("mr_pre_busy", 16'(in_busy0), 16'd1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    chk_empty("mr_rst");
    chk16("mr_busy", 16'({in_busy0, in_busy1}), 16'd0);
    chk16("mr_cnt", frame_cnt0 | frame_cnt1, 16'd0);
    rst_n    = 1'b1;
    out_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_empty($sformatf("mr_quiet_%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
